seq_signed_divider: RTL and testbench
=====================================

SEQ_SIGNED_DIVIDER -- requirements
Module: seq_signed_divider

Interface
REQ-001 Parameter WIDTH, default 16, SHALL set the operand and result width (legal range 4..64).
REQ-002 clk  input  1  SHALL be the single clock; all state updates on its rising edge.
REQ-003 rst  input  1  SHALL be the synchronous, active-high reset.
REQ-004 start  input  1  SHALL request a division; it is accepted only when busy=0.
REQ-005 Q  input  WIDTH  SHALL carry the two's-complement dividend, sampled on the accepted start.
REQ-006 M  input  WIDTH  SHALL carry the two's-complement divisor, sampled on the accepted start.
REQ-007 busy  output  1  SHALL be high while a division is in progress.
REQ-008 done  output  1  SHALL be a one-cycle pulse marking valid results.
REQ-009 Quo  output  WIDTH  SHALL be the signed quotient, truncated toward zero.
REQ-010 Rem  output  WIDTH  SHALL be the signed remainder, carrying the dividend's sign.
REQ-011 DVF  output  1  SHALL flag overflow: Q = -2^(WIDTH-1) with M = -1.
REQ-012 ZE  output  1  SHALL flag division by zero (M = 0).

Function
REQ-013 The FSM SHALL have three states:
- IDLE -> CALC on start.
- CALC -> DONE when the step counter expires.
- DONE -> IDLE after one cycle, or DONE -> CALC if start is high in that cycle.
REQ-014 On the accepted start, the block SHALL:
- latch |Q| and |M| as WIDTH-bit unsigned values (the magnitude of -2^(WIDTH-1) is 2^(WIDTH-1));
- latch the sign of Q and the sign of Q XOR M;
- clear a WIDTH+1-bit partial remainder;
- load the step counter with WIDTH.
REQ-015 Each CALC cycle SHALL perform one restoring step:
- shift {A,Qr} left by one;
- form A-|M| at WIDTH+1 bits;
- if the result is non-negative, keep it and shift in quotient bit 1; otherwise restore A and shift in 0.
REQ-016 Latency: with start accepted at edge k, the block SHALL spend WIDTH CALC cycles and assert done for exactly the cycle following edge k+WIDTH+1.
REQ-017 On entering DONE, the block SHALL register:
- Quo = Qr, negated if the sign-XOR is 1;
- Rem = A[WIDTH-1:0], negated if Q was negative.
REQ-018 Quo, Rem, DVF and ZE SHALL hold stable from done until the next accepted start.
REQ-019 On the next accepted start, the block SHALL clear DVF and ZE.
REQ-020 busy SHALL be 1 exactly in CALC; start while busy=1 SHALL be ignored with no state change.
REQ-021 On overflow, the block SHALL set DVF=1, Quo=-2^(WIDTH-1) (wrapped) and Rem=0.
REQ-022 On divide by zero, the block SHALL set ZE=1, Quo=0 and Rem=Q.
REQ-023 If M=0 and the overflow pattern would otherwise match, ZE SHALL take precedence and DVF SHALL stay 0.
REQ-024 A dividend of 0 SHALL yield Quo=0 and Rem=0 with normal latency.

Reset
REQ-025 When rst is high at a clock edge, the block SHALL:
- enter IDLE;
- set busy=0 and done=0;
- set Quo=0, Rem=0, DVF=0 and ZE=0;
- clear internal registers.
REQ-026 Reset SHALL have priority over start.
REQ-027 Reset during CALC or DONE SHALL abort the operation, and no done SHALL follow.

Configuration
REQ-028 With macro DIV_FASTPATH_EN defined, divide-by-zero and overflow SHALL skip CALC: IDLE/DONE -> DONE directly, with done asserted the cycle after the accepted-start edge.
REQ-029 Without DIV_FASTPATH_EN, those cases SHALL run the full WIDTH CALC cycles and produce done per REQ-016.
REQ-030 In both configurations, the values of Quo, Rem, DVF and ZE SHALL be identical.

Verification (WIDTH=16)
REQ-031 The bench SHALL cover these scenarios:
- Q=100, M=20, start -> done exactly 17 cycles later; Quo=5, Rem=0, DVF=0, ZE=0.
- Sign matrix: -100/20 -> Quo=-5, Rem=0; 100/-7 -> Quo=-14, Rem=2; -100/-7 -> Quo=14, Rem=-2.
- Q=-32768, M=-1 -> DVF=1, Quo=-32768, Rem=0. Q=32767, M=-1 -> Quo=-32767, DVF=0.
- Q=50, M=0 -> ZE=1, Quo=0, Rem=50. Latency is 1 cycle with DIV_FASTPATH_EN and 17 cycles without.
- Back-to-back: start held high through DONE -> second operation accepted with no IDLE cycle. start pulsed mid-CALC -> ignored, first result intact.
- rst asserted at CALC cycle 8 -> next cycle busy=0 and outputs 0; no done pulse; a subsequent 12345/1 -> Quo=12345, Rem=0.

Source files
------------

// File: rtl/seq_signed_divider.sv
// Sequential signed restoring divider.
// One quotient bit per CALC cycle, followed by a single finishing cycle in which
// the step counter reads zero and the signed results are registered.
// Optional feature: define DIV_FASTPATH_EN to let divide-by-zero and overflow
// bypass CALC and go straight to DONE. Result values are the same either way.
//
// state | meaning
// IDLE  | waiting for start
// CALC  | restoring steps while cnt != 0; result capture when cnt == 0
// DONE  | results valid, done pulse; a start here is accepted at once
module seq_signed_divider #(
  parameter int WIDTH = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [WIDTH-1:0] Q,
  input  logic [WIDTH-1:0] M,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] Quo,
  output logic [WIDTH-1:0] Rem,
  output logic             DVF,
  output logic             ZE
);

  localparam int CW = $clog2(WIDTH + 1);
  localparam logic [WIDTH-1:0] MIN_NEG = {1'b1, {(WIDTH-1){1'b0}}};

  typedef enum logic [1:0] {IDLE, CALC, DONE} state_t;

  state_t           state, next_state;
  logic [WIDTH:0]   a;
  logic [WIDTH-1:0] qr;
  logic [WIDTH-1:0] mabs;
  logic [WIDTH-1:0] q_lat;
  logic             sign_q, sign_x;
  logic             zero_lat, ovf_lat;
  logic [CW-1:0]    cnt;

  logic             accept, finish, fast;
  logic             in_zero, in_ovf;
  logic [WIDTH-1:0] q_abs, m_abs;
  logic [WIDTH:0]   shifted, diff;

  logic             sel_zero, sel_ovf;
  logic [WIDTH-1:0] sel_q;
  logic [WIDTH-1:0] res_quo, res_rem;
  logic             res_dvf, res_ze;

  // Input classification; zero divisor wins over the overflow pattern.
  assign in_zero = (M == '0);
  assign in_ovf  = !in_zero && (Q == MIN_NEG) && (M == '1);
  assign q_abs   = Q[WIDTH-1] ? -Q : Q;
  assign m_abs   = M[WIDTH-1] ? -M : M;

`ifdef DIV_FASTPATH_EN
  assign fast = in_zero | in_ovf;
`else
  assign fast = 1'b0;
`endif

  // State register.
  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= next_state;
  end

  // Next-state and control decode.
  always_comb begin
    next_state = state;
    accept     = 1'b0;
    finish     = 1'b0;
    case (state)
      IDLE: begin
        if (start) begin
          accept     = 1'b1;
          next_state = fast ? DONE : CALC;
        end
      end
      CALC: begin
        if (cnt == '0) begin
          finish     = 1'b1;
          next_state = DONE;
        end
      end
      DONE: begin
        if (start) begin
          accept     = 1'b1;
          next_state = fast ? DONE : CALC;
        end else begin
          next_state = IDLE;
        end
      end
      default: next_state = IDLE;
    endcase
  end

  assign busy = (state == CALC);
  assign done = (state == DONE);

  // One restoring step: shift {A,Qr} left and trial-subtract |M|.
  always_comb begin
    shifted = {a[WIDTH-1:0], qr[WIDTH-1]};
    diff    = shifted - {1'b0, mabs};
  end

  // Final result selection; on a fast-path accept the live inputs are used.
  always_comb begin
    sel_zero = accept ? in_zero : zero_lat;
    sel_ovf  = accept ? in_ovf  : ovf_lat;
    sel_q    = accept ? Q       : q_lat;
    res_quo  = sign_x ? -qr : qr;
    res_rem  = sign_q ? -a[WIDTH-1:0] : a[WIDTH-1:0];
    res_dvf  = 1'b0;
    res_ze   = 1'b0;
    if (sel_zero) begin
      res_quo = '0;
      res_rem = sel_q;
      res_ze  = 1'b1;
    end else if (sel_ovf) begin
      res_quo = MIN_NEG;
      res_rem = '0;
      res_dvf = 1'b1;
    end
  end

  // Operand capture, iteration and result registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      a        <= '0;
      qr       <= '0;
      mabs     <= '0;
      q_lat    <= '0;
      sign_q   <= 1'b0;
      sign_x   <= 1'b0;
      zero_lat <= 1'b0;
      ovf_lat  <= 1'b0;
      cnt      <= '0;
      Quo      <= '0;
      Rem      <= '0;
      DVF      <= 1'b0;
      ZE       <= 1'b0;
    end else if (accept) begin
      a        <= '0;
      qr       <= q_abs;
      mabs     <= m_abs;
      q_lat    <= Q;
      sign_q   <= Q[WIDTH-1];
      sign_x   <= Q[WIDTH-1] ^ M[WIDTH-1];
      zero_lat <= in_zero;
      ovf_lat  <= in_ovf;
      cnt      <= CW'(WIDTH);
      if (fast) begin
        Quo <= res_quo;
        Rem <= res_rem;
        DVF <= res_dvf;
        ZE  <= res_ze;
      end else begin
        DVF <= 1'b0;
        ZE  <= 1'b0;
      end
    end else if (state == CALC) begin
      if (finish) begin
        Quo <= res_quo;
        Rem <= res_rem;
        DVF <= res_dvf;
        ZE  <= res_ze;
      end else begin
        cnt <= cnt - 1'b1;
        if (!diff[WIDTH]) begin
          a  <= diff;
          qr <= {qr[WIDTH-2:0], 1'b1};
        end else begin
          a  <= shifted;
          qr <= {qr[WIDTH-2:0], 1'b0};
        end
      end
    end
  end

endmodule

// File: tb/tb_seq_signed_divider.sv
// Scoreboard bench for seq_signed_divider (WIDTH=16): directed vectors push
// expected results; a negedge monitor pops and compares on every done pulse.
module tb_seq_signed_divider;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        start = 1'b0;
  logic [15:0] Q = '0;
  logic [15:0] M = '0;
  logic        busy, done, DVF, ZE;
  logic [15:0] Quo, Rem;

  int checks = 0;
  int fails  = 0;
  int cyc    = 0;

  typedef struct {
    string       name;
    logic [15:0] quo;
    logic [15:0] rem;
    logic        dvf;
    logic        ze;
    int          acc;
    int          lat;
  } exp_t;

  exp_t expq[$];

  seq_signed_divider #(.WIDTH(16)) dut (
    .clk(clk), .rst(rst), .start(start), .Q(Q), .M(M),
    .busy(busy), .done(done), .Quo(Quo), .Rem(Rem), .DVF(DVF), .ZE(ZE)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h, expected %0h", nm, act, exp);
    end
  endtask

  function automatic int exp_lat(input logic special);
`ifdef DIV_FASTPATH_EN
    return special ? 1 : 17;
`else
    return 17;
`endif
  endfunction

  function automatic exp_t mk(input string nm, input logic [15:0] eq, input logic [15:0] er,
                              input logic edvf, input logic eze, input int acc);
    exp_t e;
    e.name = nm; e.quo = eq; e.rem = er; e.dvf = edvf; e.ze = eze;
    e.acc = acc; e.lat = exp_lat(edvf | eze);
    return e;
  endfunction

  // Monitor: every done pulse must match the oldest outstanding expectation.
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      if (!rst && done) begin
        if (expq.size() == 0) begin
          checks++;
          fails++;
          $display("FAIL unexpected_done: got done=1 at cycle %0d, expected no pulse", cyc);
        end else begin
          e = expq.pop_front();
          chk({e.name, "_quo"}, {16'h0, Quo}, {16'h0, e.quo});
          chk({e.name, "_rem"}, {16'h0, Rem}, {16'h0, e.rem});
          chk({e.name, "_dvf"}, {31'h0, DVF}, {31'h0, e.dvf});
          chk({e.name, "_ze"},  {31'h0, ZE},  {31'h0, e.ze});
          chk({e.name, "_lat"}, cyc - e.acc, e.lat);
        end
      end
    end
  end

  task automatic issue(input string nm, input logic [15:0] qv, input logic [15:0] mv,
                       input logic [15:0] eq, input logic [15:0] er,
                       input logic edvf, input logic eze);
    @(negedge clk);
    Q = qv; M = mv; start = 1'b1;
    expq.push_back(mk(nm, eq, er, edvf, eze, cyc + 1));
    @(negedge clk);
    start = 1'b0;
  endtask

  task automatic wait_quiet(input string nm);
    for (int i = 0; i < 200; i++) begin
      @(negedge clk);
      if (expq.size() == 0 && !busy && !done) return;
    end
    checks++;
    fails++;
    $display("FAIL %s_timeout: got %0d results outstanding, expected 0", nm, expq.size());
    expq.delete();
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got no finish by 200000ns, expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    bit seen;
    repeat (3) @(negedge clk);
    chk("rst_busy", {31'h0, busy}, 32'h0);
    chk("rst_done", {31'h0, done}, 32'h0);
    chk("rst_quo",  {16'h0, Quo},  32'h0);
    chk("rst_rem",  {16'h0, Rem},  32'h0);
    chk("rst_dvf",  {31'h0, DVF},  32'h0);
    chk("rst_ze",   {31'h0, ZE},   32'h0);
    rst = 1'b0;

    issue("p100_20",  16'd100,     16'd20,     16'd5,      16'd0,      1'b0, 1'b0); wait_quiet("p100_20");
    issue("n100_20",  16'hFF9C,    16'd20,     16'hFFFB,   16'd0,      1'b0, 1'b0); wait_quiet("n100_20");
    issue("p100_n7",  16'd100,     16'hFFF9,   16'hFFF2,   16'd2,      1'b0, 1'b0); wait_quiet("p100_n7");
    issue("n100_n7",  16'hFF9C,    16'hFFF9,   16'd14,     16'hFFFE,   1'b0, 1'b0); wait_quiet("n100_n7");
    issue("ovf",      16'h8000,    16'hFFFF,   16'h8000,   16'd0,      1'b1, 1'b0); wait_quiet("ovf");
    issue("max_n1",   16'h7FFF,    16'hFFFF,   16'h8001,   16'd0,      1'b0, 1'b0); wait_quiet("max_n1");
    issue("dz50",     16'd50,      16'd0,      16'd0,      16'd50,     1'b0, 1'b1); wait_quiet("dz50");
    issue("dzmin",    16'h8000,    16'd0,      16'd0,      16'h8000,   1'b0, 1'b1); wait_quiet("dzmin");
    issue("zero_div", 16'd0,       16'd5,      16'd0,      16'd0,      1'b0, 1'b0); wait_quiet("zero_div");
    issue("small",    16'd7,       16'd100,    16'd0,      16'd7,      1'b0, 1'b0); wait_quiet("small");

    // Back-to-back: start held high through DONE.
    @(negedge clk);
    Q = 16'd100; M = 16'd20; start = 1'b1;
    expq.push_back(mk("b2b_a", 16'd5, 16'd0, 1'b0, 1'b0, cyc + 1));
    @(negedge clk);
    Q = 16'hFF9C; M = 16'hFFF9;
    seen = 1'b0;
    for (int i = 0; i < 40; i++) begin
      if (done) begin seen = 1'b1; break; end
      @(negedge clk);
    end
    if (!seen) begin
      checks++; fails++;
      $display("FAIL b2b_wait: got no done within 40 cycles, expected done");
    end else begin
      expq.push_back(mk("b2b_b", 16'd14, 16'hFFFE, 1'b0, 1'b0, cyc + 1));
      @(negedge clk);
      chk("b2b_no_idle", {31'h0, busy}, 32'h1);
    end
    start = 1'b0;
    wait_quiet("b2b");

    // start pulsed in the middle of CALC is ignored.
    issue("midcalc", 16'hFFF9, 16'd2, 16'hFFFD, 16'hFFFF, 1'b0, 1'b0);
    repeat (5) @(negedge clk);
    Q = 16'd1; M = 16'd1; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    wait_quiet("midcalc");

    // Reset during CALC cycle 8 aborts the operation.
    issue("aborted", 16'd1000, 16'd3, 16'd333, 16'd1, 1'b0, 1'b0);
    repeat (6) @(negedge clk);
    rst = 1'b1;
    void'(expq.pop_back());
    @(negedge clk);
    chk("abort_busy", {31'h0, busy}, 32'h0);
    chk("abort_done", {31'h0, done}, 32'h0);
    chk("abort_quo",  {16'h0, Quo},  32'h0);
    chk("abort_rem",  {16'h0, Rem},  32'h0);
    rst = 1'b0;
    repeat (25) @(negedge clk);
    issue("after_rst", 16'd12345, 16'd1, 16'd12345, 16'd0, 1'b0, 1'b0); wait_quiet("after_rst");

    repeat (3) @(negedge clk);
    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end

endmodule
